// File: rtl/draw_sequencer.sv
// Pong display sequencer: clears the screen, draws the centre line, then
// paces erase/update/redraw passes to the frame tick and drives the plot strobe.
module draw_sequencer #(
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int MID_X     = 80,
    parameter int FRAME_DIV = 833333
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [2:0] state,
    output logic [7:0] init_x,
    output logic [6:0] init_y,
    output logic [7:0] ui_x,
    output logic [6:0] ui_y,
    output logic       ball_go,
    input  logic       ball_busy,
    output logic       pad_go,
    input  logic       pad_busy,
    output logic       update,
    output logic       plot,
    output logic       frame_overrun
);

    localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_UI    = 3'd1,
        S_DBALL = 3'd2,
        S_EBALL = 3'd3,
        S_DPAD  = 3'd4,
        S_EPAD  = 3'd5,
        S_WAIT  = 3'd6,
        S_UPD   = 3'd7
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    init_x_q, init_x_d;
    logic [6:0]    init_y_q, init_y_d;
    logic [6:0]    ui_y_q, ui_y_d;
    logic          seen_q, seen_d;
    logic          plot_q, plot_d;
    logic          pend_q, pend_d;
    logic          ovr_q, ovr_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          tick, pend_clr;
    logic          gen_ball, gen_busy;
    state_e        gen_next;

    // A tick setting pending wins over the WAIT_FRAME clear.
    assign tick   = (fcnt_q == FW'(FRAME_DIV - 1));
    assign fcnt_d = tick ? '0 : fcnt_q + FW'(1);
    assign pend_d = tick | (pend_q & ~pend_clr);
    assign ovr_d  = ovr_q | (tick & pend_q);

    always_comb begin
        gen_ball = (state_q == S_DBALL) || (state_q == S_EBALL);
        gen_busy = gen_ball ? ball_busy : pad_busy;
        case (state_q)
            S_EBALL: gen_next = S_EPAD;
            S_EPAD:  gen_next = S_UPD;
            S_DPAD:  gen_next = S_DBALL;
            default: gen_next = S_WAIT;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        init_x_d = init_x_q;
        init_y_d = init_y_q;
        ui_y_d   = ui_y_q;
        seen_d   = 1'b0;
        plot_d   = 1'b0;
        pend_clr = 1'b0;
        ball_go  = 1'b0;
        pad_go   = 1'b0;
        update   = 1'b0;
        case (state_q)
            S_INIT: begin
                plot_d = 1'b1;
                ui_y_d = '0;
                if (init_x_q == 8'(SCREEN_W - 1)) begin
                    init_x_d = '0;
                    if (init_y_q == 7'(SCREEN_H - 1)) begin
                        init_y_d = '0;
                        state_d  = S_UI;
                    end else begin
                        init_y_d = init_y_q + 7'd1;
                    end
                end else begin
                    init_x_d = init_x_q + 8'd1;
                end
            end
            S_UI: begin
                plot_d = 1'b1;
                if (ui_y_q == 7'(SCREEN_H - 1)) begin
                    ui_y_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    ui_y_d = ui_y_q + 7'd1;
                end
            end
            S_WAIT: begin
                if (pend_q) begin
                    pend_clr = 1'b1;
                    state_d  = S_EBALL;
                end
            end
            S_UPD: begin
                update  = 1'b1;
                state_d = S_DPAD;
            end
            default: begin
                // seen_q low marks the entry (go) cycle of a generator state
                ball_go = gen_ball & ~seen_q;
                pad_go  = ~gen_ball & ~seen_q;
                plot_d  = seen_q & gen_busy;
                seen_d  = 1'b1;
                if (seen_q && !gen_busy) begin
                    seen_d  = 1'b0;
                    state_d = gen_next;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_INIT;
            init_x_q <= '0;
            init_y_q <= '0;
            ui_y_q   <= '0;
            seen_q   <= 1'b0;
            plot_q   <= 1'b0;
            pend_q   <= 1'b0;
            ovr_q    <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            init_x_q <= init_x_d;
            init_y_q <= init_y_d;
            ui_y_q   <= ui_y_d;
            seen_q   <= seen_d;
            plot_q   <= plot_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign state         = state_q;
    assign init_x        = init_x_q;
    assign init_y        = init_y_q;
    assign ui_x          = 8'(MID_X);
    assign ui_y          = ui_y_q;
    assign plot          = plot_q;
    assign frame_overrun = ovr_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: full-size clear/centre-line scan, frame
// phase table, overrun, tick/exit coincidence and asynchronous reset.
module tb_draw_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nbad = 0;
    int cyc  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // u0: default geometry
    logic       rst0 = 1'b0, bb0 = 1'b0, pb0 = 1'b0;
    logic [2:0] st0;
    logic [7:0] ix0, ux0;
    logic [6:0] iy0, uy0;
    logic       bg0, pg0, up0, pl0, ov0;

    draw_sequencer u0 (
        .clk(clk), .resetn(rst0), .state(st0),
        .init_x(ix0), .init_y(iy0), .ui_x(ux0), .ui_y(uy0),
        .ball_go(bg0), .ball_busy(bb0), .pad_go(pg0), .pad_busy(pb0),
        .update(up0), .plot(pl0), .frame_overrun(ov0)
    );

    // u1: 4x2 screen, FRAME_DIV=50
    logic       rst1 = 1'b0, bb1 = 1'b0, pb1 = 1'b0;
    logic [2:0] st1;
    logic [7:0] ix1, ux1;
    logic [6:0] iy1, uy1;
    logic       bg1, pg1, up1, pl1, ov1;

    draw_sequencer #(.SCREEN_W(4), .SCREEN_H(2), .MID_X(2), .FRAME_DIV(50)) u1 (
        .clk(clk), .resetn(rst1), .state(st1),
        .init_x(ix1), .init_y(iy1), .ui_x(ux1), .ui_y(uy1),
        .ball_go(bg1), .ball_busy(bb1), .pad_go(pg1), .pad_busy(pb1),
        .update(up1), .plot(pl1), .frame_overrun(ov1)
    );

    // u2: 4x2 screen, FRAME_DIV=20
    logic       rst2 = 1'b0, bb2 = 1'b0, pb2 = 1'b0;
    logic [2:0] st2;
    logic [7:0] ix2, ux2;
    logic [6:0] iy2, uy2;
    logic       bg2, pg2, up2, pl2, ov2;

    draw_sequencer #(.SCREEN_W(4), .SCREEN_H(2), .MID_X(2), .FRAME_DIV(20)) u2 (
        .clk(clk), .resetn(rst2), .state(st2),
        .init_x(ix2), .init_y(iy2), .ui_x(ux2), .ui_y(uy2),
        .ball_go(bg2), .ball_busy(bb2), .pad_go(pg2), .pad_busy(pb2),
        .update(up2), .plot(pl2), .frame_overrun(ov2)
    );

    typedef struct {
        logic [2:0] st;
        int         busy;
        int         dur;
        int         plot_n;
        int         go_n;
        int         upd_n;
    } phase_t;

    phase_t     ph[5];
    logic [2:0] tail[11];

    int  bad_init, bad_ui, c, pn, gb, gp, un, bz;
    logic ball;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // state, busy length, duration, plot cycles, go pulses, update pulses
        ph[0] = '{3'd3, 4, 6, 4, 1, 0};
        ph[1] = '{3'd5, 6, 8, 6, 1, 0};
        ph[2] = '{3'd7, 0, 1, 0, 0, 1};
        ph[3] = '{3'd4, 6, 8, 6, 1, 0};
        ph[4] = '{3'd2, 4, 6, 4, 1, 0};
        tail  = '{3'd3, 3'd3, 3'd5, 3'd5, 3'd7, 3'd4, 3'd4,
                  3'd2, 3'd2, 3'd6, 3'd3};

        repeat (3) @(negedge clk);
        chk("rst_state", st0, 0);
        chk("rst_init_x", ix0, 0);
        chk("rst_init_y", iy0, 0);
        chk("rst_ui_y", uy0, 0);
        chk("rst_plot", pl0, 0);
        chk("rst_pulses", {bg0, pg0, up0}, 0);
        chk("rst_overrun", ov0, 0);

        // Full-size clear and centre line
        rst0 = 1'b1;
        bad_init = 0;
        bad_ui = 0;
        for (int k = 0; k <= 19321; k++) begin
            if (k < 19200) begin
                if (st0 !== 3'd0 || ix0 !== 8'(k % 160) ||
                    iy0 !== 7'(k / 160) || pl0 !== (k >= 1) ||
                    (bg0 | pg0 | up0) !== 1'b0)
                    bad_init++;
            end else if (k < 19320) begin
                if (st0 !== 3'd1 || uy0 !== 7'(k - 19200) ||
                    ux0 !== 8'd80 || pl0 !== 1'b1)
                    bad_ui++;
            end else if (k == 19320) begin
                chk("wait_entry_state", st0, 6);
                chk("wait_entry_plot_lag", pl0, 1);
            end else begin
                chk("wait_hold_state", st0, 6);
                chk("wait_plot_off", pl0, 0);
            end
            @(negedge clk);
        end
        chk("init_scan_bad_cycles", bad_init, 0);
        chk("ui_scan_bad_cycles", bad_ui, 0);
        rst0 = 1'b0;

        // Frame order and per-phase timing, FRAME_DIV=50
        rst1 = 1'b1;
        cyc = 0;
        while (st1 !== 3'd3 && cyc < 200) step();
        chk("frame1_start_cycle", cyc, 51);
        for (int p = 0; p < 5; p++) begin
            chk("phase_entry_state", st1, ph[p].st);
            ball = (ph[p].st == 3'd3) || (ph[p].st == 3'd2);
            c = 0; pn = 0; gb = 0; gp = 0; un = 0;
            while (st1 === ph[p].st && c < 64) begin
                bz  = (c >= 1 && c <= ph[p].busy) ? 1 : 0;
                bb1 = ball && (bz != 0);
                pb1 = !ball && (bz != 0);
                if (c >= 1) pn += int'(pl1);
                gb += int'(bg1);
                gp += int'(pg1);
                un += int'(up1);
                c++;
                step();
            end
            bb1 = 1'b0;
            pb1 = 1'b0;
            pn += int'(pl1);
            chk("phase_duration", c, ph[p].dur);
            chk("phase_plot_cycles", pn, ph[p].plot_n);
            chk("phase_ball_go", gb, ball ? ph[p].go_n : 0);
            chk("phase_pad_go", gp, ball ? 0 : ph[p].go_n);
            chk("phase_update", un, ph[p].upd_n);
        end
        chk("frame1_wait_cycle", cyc, 80);
        while (st1 !== 3'd3 && cyc < 200) step();
        chk("frame2_start_cycle", cyc, 101);

        // Async reset in the middle of DRAW_PADDLES
        while (cyc < 106) step();
        chk("pre_rst_state", st1, 4);
        chk("pre_rst_pad_go", pg1, 1);
        pb1 = 1'b1;
        step();
        step();
        chk("pre_rst_plot", pl1, 1);
        #2 rst1 = 1'b0;
        #1;
        chk("async_rst_state", st1, 0);
        chk("async_rst_plot", pl1, 0);
        chk("async_rst_pad_go", pg1, 0);
        chk("async_rst_xy", {ix1, 1'b0, iy1, 1'b0, uy1}, 0);
        pb1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        cyc = 0;
        chk("restart_x0", ix1, 0);
        step();
        chk("restart_x1", ix1, 1);
        repeat (4) step();
        chk("restart_wrap_x", ix1, 1);
        chk("restart_wrap_y", iy1, 1);
        while (st1 !== 3'd3 && cyc < 200) step();
        chk("restart_frame_cycle", cyc, 51);
        rst1 = 1'b0;

        // Overrun, tick on WAIT exit, idle generators, FRAME_DIV=20
        @(negedge clk);
        rst2 = 1'b1;
        cyc = 0;
        while (cyc <= 110) begin
            pb2 = (cyc >= 24 && cyc <= 63) || (cyc >= 74 && cyc <= 92);
            bb2 = 1'b0;
            if (cyc == 21) chk("ov_eball_go", {st2, bg2}, {3'd3, 1'b1});
            if (cyc == 23) chk("ov_epad_go", {st2, pg2}, {3'd5, 1'b1});
            if (cyc == 59) chk("ov_before", ov2, 0);
            if (cyc == 60) chk("ov_set", ov2, 1);
            if (cyc == 64) chk("ov_epad_last", st2, 5);
            if (cyc == 65) chk("ov_update", {st2, up2}, {3'd7, 1'b1});
            if (cyc == 70) chk("ov_wait_one", st2, 6);
            if (cyc == 71) chk("ov_next_frame", st2, 3);
            if (cyc == 93) chk("co_epad_last", st2, 5);
            if (cyc == 99) chk("co_wait_on_tick", st2, 6);
            if (cyc >= 100) begin
                chk("co_seq_state", st2, tail[cyc - 100]);
                chk("co_idle_plot", pl2, 0);
            end
            step();
        end
        chk("ov_sticky", ov2, 1);
        pb2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Master sequencer for the Pong display path; sits directly upstream of the draw control centre.
- Outputs the 3-bit draw state that selects the coordinate/colour source.
- Generates the clear-screen and centre-line coordinates itself.
- Handshakes with the ball and paddle pixel generators, paces redraws to a 60 Hz frame tick, and produces the VGA plot strobe aligned with the draw centre's registered outputs.

Parameters:
- SCREEN_W, 160, screen width in pixels; init_x counts 0..SCREEN_W-1.
- SCREEN_H, 120, screen height in pixels; init_y and ui_y count 0..SCREEN_H-1.
- MID_X, 80, x column of the centre line.
- FRAME_DIV, 833333, clk cycles per frame tick (50 MHz / 60).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- state  out  3  draw state: 0 INIT, 1 DRAW_UI, 2 DRAW_BALL, 3 ERASE_BALL, 4 DRAW_PADDLES, 5 ERASE_PADDLES, 6 WAIT_FRAME, 7 UPDATE
- init_x  out  8  clear-screen x
- init_y  out  7  clear-screen y
- ui_x  out  8  centre-line x; constant MID_X
- ui_y  out  7  centre-line y
- ball_go  out  1  one-cycle start pulse to ball generator
- ball_busy  in  1  ball generator emitting a pixel this cycle
- pad_go  out  1  one-cycle start pulse to paddle generator
- pad_busy  in  1  paddle generator emitting a pixel this cycle
- update  out  1  one-cycle pulse; game logic advances positions
- plot  out  1  VGA write enable; one cycle delayed from the pixel-source cycle
- frame_overrun  out  1  sticky; set when a tick arrives while one is already pending

Behaviour:
- Reset (async, resetn=0): state=INIT, init_x=init_y=ui_y=0, all pulses 0, plot=0, frame counter=0, tick_pending=0, frame_overrun=0.
  - Reset asserted mid-sequence aborts immediately.
  - After release the sequence restarts with a full screen clear.
- INIT:
  - Raster scan: init_x increments every cycle; at SCREEN_W-1 it wraps to 0 and init_y increments.
  - At (SCREEN_W-1, SCREEN_H-1) the next state is DRAW_UI.
  - Duration is exactly SCREEN_W*SCREEN_H cycles (19200 at defaults).
- DRAW_UI:
  - ui_y counts 0..SCREEN_H-1, one per cycle; ui_y is reset to 0 on entry.
  - After the last row the next state is WAIT_FRAME.
  - Duration is SCREEN_H cycles.
- WAIT_FRAME: hold until tick_pending=1. On leaving, clear tick_pending and go to ERASE_BALL.
- Generator states (ERASE_BALL, ERASE_PADDLES, DRAW_PADDLES, DRAW_BALL):
  - On the entry cycle the matching go pulses for exactly one cycle (ball_go for ball states, pad_go for paddle states).
  - The generator raises busy the cycle after go.
  - The sequencer leaves the state on the first cycle, at least 2 cycles after entry, in which busy=0.
  - A generator that never raises busy therefore costs 2 cycles, not a hang.
- Fixed frame order: ERASE_BALL -> ERASE_PADDLES -> UPDATE -> DRAW_PADDLES -> DRAW_BALL -> WAIT_FRAME.
- UPDATE: exactly one cycle with update=1, then DRAW_PADDLES.
- Frame counter:
  - Free-running 0..FRAME_DIV-1; it runs during INIT and DRAW_UI as well.
  - At the wrap it produces a tick, which sets tick_pending.
  - A tick arriving while tick_pending=1 sets frame_overrun; it stays set until reset.
  - A tick in the same cycle as WAIT_FRAME exit is not lost: the set takes priority over the clear.
- plot is registered; plot(t+1) = plot_src(t), where plot_src is:
  - 1 every cycle of INIT and DRAW_UI;
  - 1 in generator states when the corresponding busy=1;
  - 0 in WAIT_FRAME, UPDATE, and every go cycle.
- Widths: the y counters wrap at SCREEN_H-1, never at the 7-bit natural limit. The frame counter is sized to ceil(log2(FRAME_DIV)).

Test Plan:
- Reset release, generators tied busy=0 -> 19200 INIT cycles with plot high (one-cycle lag), then DRAW_UI 120 cycles with ui_x=80 and ui_y 0..119, then WAIT_FRAME.
- FRAME_DIV=50, ball generator holds busy 4 cycles, paddle generator 6 cycles -> states visit 3,5,7,4,2,6 in order; exactly one go pulse per generator state; update high 1 cycle; plot high 4/6/6/4 cycles per state, each lagged by one.
- FRAME_DIV=20, paddle busy held 40 cycles -> second tick while pending sets frame_overrun=1, and the next frame starts immediately after DRAW_BALL.
- resetn pulled low mid-DRAW_PADDLES -> outputs return to reset values in the same cycle (async); after release INIT restarts at (0,0).
- Tick coincides with the WAIT_FRAME exit cycle -> tick_pending is 1 after the exit and the following frame starts with no idle WAIT_FRAME cycles beyond one.
- Generators never assert busy -> each generator state lasts exactly 2 cycles; plot stays 0 throughout them.
